// File: rtl/apu_fpu_rsp_buffer.sv
// rtl/apu_fpu_rsp_buffer.sv - credit-throttled FPU request pass-through with registered response FIFO
// Issue is held back so in-flight plus buffered results never exceed RSP_DEPTH; the FPU output is never stalled.
module apu_fpu_rsp_buffer #(
  parameter int ID_WIDTH        = 9,
  parameter int NB_ARGS         = 3,
  parameter int OPCODE_WIDTH    = 6,
  parameter int DATA_WIDTH      = 32,
  parameter int FLAGS_IN_WIDTH  = 15,
  parameter int FLAGS_OUT_WIDTH = 5,
  parameter int RSP_DEPTH       = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          apu_req_i,
  output logic                          apu_gnt_o,
  input  logic [ID_WIDTH-1:0]           apu_ID_i,
  input  logic [NB_ARGS*DATA_WIDTH-1:0] apu_operands_i,
  input  logic [OPCODE_WIDTH-1:0]       apu_op_i,
  input  logic [FLAGS_IN_WIDTH-1:0]     apu_flags_i,
  input  logic                          apu_rready_i,
  output logic                          apu_rvalid_o,
  output logic [DATA_WIDTH-1:0]         apu_rdata_o,
  output logic [FLAGS_OUT_WIDTH-1:0]    apu_rflags_o,
  output logic [ID_WIDTH-1:0]           apu_rID_o,
  output logic                          fpu_req_o,
  input  logic                          fpu_gnt_i,
  output logic [ID_WIDTH-1:0]           fpu_ID_o,
  output logic [NB_ARGS*DATA_WIDTH-1:0] fpu_operands_o,
  output logic [OPCODE_WIDTH-1:0]       fpu_op_o,
  output logic [FLAGS_IN_WIDTH-1:0]     fpu_flags_o,
  input  logic                          fpu_rvalid_i,
  input  logic [DATA_WIDTH-1:0]         fpu_rdata_i,
  input  logic [FLAGS_OUT_WIDTH-1:0]    fpu_rflags_i,
  input  logic [ID_WIDTH-1:0]           fpu_rID_i,
  output logic                          busy_o,
  output logic                          ovf_err_o
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int EW = DATA_WIDTH + FLAGS_OUT_WIDTH + ID_WIDTH;
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(RSP_DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(RSP_DEPTH - 1);

  logic [CW-1:0] outstanding;
  logic [CW-1:0] count;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [EW-1:0] mem [RSP_DEPTH];

  logic [CW:0] used;
  logic        credit_ok;
  logic        issue;
  logic        full;
  logic        pop;
  logic        rsp_ok;
  logic        push;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + PW'(1);
  endfunction

  // Credits come from registered state only, so a pop frees its slot one cycle later.
  assign used      = {1'b0, outstanding} + {1'b0, count};
  assign credit_ok = used < DEPTH_C;

  assign fpu_req_o      = apu_req_i & credit_ok;
  assign apu_gnt_o      = fpu_gnt_i & credit_ok;
  assign fpu_ID_o       = apu_ID_i;
  assign fpu_operands_o = apu_operands_i;
  assign fpu_op_o       = apu_op_i;
  assign fpu_flags_o    = apu_flags_i;

  assign issue        = fpu_req_o & fpu_gnt_i;
  assign full         = (count == DEPTH_C[CW-1:0]);
  assign apu_rvalid_o = (count != '0);
  assign pop          = apu_rvalid_o & apu_rready_i;
  assign rsp_ok       = fpu_rvalid_i & (outstanding != '0);
  assign push         = rsp_ok & (!full | pop);

  assign {apu_rdata_o, apu_rflags_o, apu_rID_o} = mem[head];
  assign busy_o = (outstanding != '0) | apu_rvalid_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
      ovf_err_o   <= 1'b0;
      for (int i = 0; i < RSP_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (issue && !rsp_ok && outstanding != DEPTH_C[CW-1:0])
        outstanding <= outstanding + CW'(1);
      else if (rsp_ok && !issue)
        outstanding <= outstanding - CW'(1);

      if (push) begin
        mem[tail] <= {fpu_rdata_i, fpu_rflags_i, fpu_rID_i};
        tail      <= ptr_next(tail);
      end
      if (pop) head <= ptr_next(head);

      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);

      // Unexpected or unstorable results are dropped and remembered.
      if (fpu_rvalid_i && !push) ovf_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_apu_fpu_rsp_buffer.sv
// tb/tb_apu_fpu_rsp_buffer.sv - self-checking bench with latency-2 FPU model and response scoreboard
module tb_apu_fpu_rsp_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        apu_req;
  logic        apu_gnt;
  logic [8:0]  apu_id;
  logic [95:0] apu_opnd;
  logic [5:0]  apu_op;
  logic [14:0] apu_flags;
  logic        apu_rready;
  logic        apu_rvalid;
  logic [31:0] apu_rdata;
  logic [4:0]  apu_rflags;
  logic [8:0]  apu_rid;
  logic        fpu_req;
  logic        fpu_gnt;
  logic [8:0]  fpu_id;
  logic [95:0] fpu_opnd;
  logic [5:0]  fpu_op;
  logic [14:0] fpu_flags;
  logic        fpu_rvalid;
  logic [31:0] fpu_rdata;
  logic [4:0]  fpu_rflags;
  logic [8:0]  fpu_rid;
  logic        busy;
  logic        ovf_err;

  logic        s1_v, s2_v;
  logic [8:0]  s1_id, s2_id;
  logic [31:0] s1_d, s2_d;
  logic [4:0]  s1_f, s2_f;
  logic        man_v;
  logic [31:0] man_d;

  int checks = 0;
  int failures = 0;
  int pop_cnt = 0;
  logic inj = 1'b0;

  typedef struct packed {
    logic [8:0]  id;
    logic [31:0] data;
    logic [4:0]  flags;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic        req;
    logic        gnt;
    logic [8:0]  id;
    logic [5:0]  op;
    logic [14:0] flags;
    logic [95:0] opnd;
    logic        exp_freq;
    logic        exp_agnt;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  apu_fpu_rsp_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .apu_req_i(apu_req), .apu_gnt_o(apu_gnt), .apu_ID_i(apu_id),
    .apu_operands_i(apu_opnd), .apu_op_i(apu_op), .apu_flags_i(apu_flags),
    .apu_rready_i(apu_rready), .apu_rvalid_o(apu_rvalid), .apu_rdata_o(apu_rdata),
    .apu_rflags_o(apu_rflags), .apu_rID_o(apu_rid),
    .fpu_req_o(fpu_req), .fpu_gnt_i(fpu_gnt), .fpu_ID_o(fpu_id),
    .fpu_operands_o(fpu_opnd), .fpu_op_o(fpu_op), .fpu_flags_o(fpu_flags),
    .fpu_rvalid_i(fpu_rvalid), .fpu_rdata_i(fpu_rdata), .fpu_rflags_i(fpu_rflags),
    .fpu_rID_i(fpu_rid), .busy_o(busy), .ovf_err_o(ovf_err)
  );

  // Fixed-latency FPU: result appears two cycles after issue, flushed by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      s1_v  <= fpu_req & fpu_gnt;
      s1_id <= fpu_id;
      s1_d  <= fpu_opnd[31:0] ^ fpu_opnd[63:32] ^ fpu_opnd[95:64];
      s1_f  <= fpu_op[4:0] ^ fpu_flags[4:0];
      s2_v  <= s1_v;
      s2_id <= s1_id;
      s2_d  <= s1_d;
      s2_f  <= s1_f;
    end
  end

  assign fpu_rvalid = s2_v | man_v;
  assign fpu_rdata  = man_v ? man_d : s2_d;
  assign fpu_rflags = man_v ? 5'h1f : s2_f;
  assign fpu_rid    = man_v ? 9'h1ff : s2_id;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] mk_opnd(input logic [8:0] t);
    return {32'(t) * 32'h01010101, ~{23'h0, t}, 32'hA5A50000 | {23'h0, t}};
  endfunction

  // Monitor: scoreboard push on grant, pop/compare on handshake, hold and latency rules.
  logic        p_stall, p_frv, p_rv;
  logic [45:0] p_payload;
  always @(negedge clk) begin
    #3;
    if (!rst_n) begin
      p_stall = 1'b0;
      p_frv   = 1'b0;
      p_rv    = 1'b0;
    end else begin
      if (apu_rvalid && apu_rready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_unexpected actual_id=%0h required=no_response", apu_rid);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_id", apu_rid, e.id);
          chk("rsp_data", apu_rdata, e.data);
          chk("rsp_flags", apu_rflags, e.flags);
        end
      end
      if (p_stall) begin
        chk("hold_valid", apu_rvalid, 1);
        chk("hold_payload", {apu_rdata, apu_rflags, apu_rid}, p_payload);
      end
      if (!inj) begin
        if (p_frv) chk("rsp_latency", apu_rvalid, 1);
        if (apu_rvalid && !p_rv) chk("no_bypass", p_frv, 1);
      end
      if (apu_req && apu_gnt)
        exp_q.push_back('{apu_id, apu_opnd[31:0] ^ apu_opnd[63:32] ^ apu_opnd[95:64],
                          apu_op[4:0] ^ apu_flags[4:0]});
      p_stall   = apu_rvalid && !apu_rready;
      p_payload = {apu_rdata, apu_rflags, apu_rid};
      p_frv     = fpu_rvalid;
      p_rv      = apu_rvalid;
    end
  end

  task automatic wait_idle();
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      #1;
      if (!busy) break;
    end
    chk("idle_reached", busy, 0);
  endtask

  task automatic issue_one(input logic [8:0] t, input logic [95:0] o);
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      apu_req = 1'b1; apu_id = t; apu_opnd = o;
      #1;
      if (apu_gnt) begin ok = 1'b1; break; end
    end
    @(negedge clk);
    apu_req = 1'b0;
    chk("issue_granted", ok, 1);
  endtask

  initial begin
    int granted, pc0, c;
    logic [8:0] tag;
    logic found;

    vecs[0] = '{1'b0, 1'b0, 9'h000, 6'h00, 15'h0000, mk_opnd(9'h000), 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 9'h123, 6'h2a, 15'h7fff, mk_opnd(9'h123), 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 9'h0f0, 6'h15, 15'h1234, mk_opnd(9'h0f0), 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 9'h1aa, 6'h3f, 15'h5555, mk_opnd(9'h1aa), 1'b1, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 9'h055, 6'h01, 15'h2aaa, mk_opnd(9'h055), 1'b1, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 9'h1ff, 6'h20, 15'h0001, mk_opnd(9'h1ff), 1'b1, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 9'h0a5, 6'h0c, 15'h4000, mk_opnd(9'h0a5), 1'b0, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 9'h101, 6'h33, 15'h0f0f, mk_opnd(9'h101), 1'b1, 1'b1};

    rst_n = 1'b0; apu_req = 1'b0; apu_id = '0; apu_opnd = '0; apu_op = '0; apu_flags = '0;
    apu_rready = 1'b0; fpu_gnt = 1'b1; man_v = 1'b0; man_d = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_gnt", apu_gnt, 1);
    chk("rst_rvalid", apu_rvalid, 0);
    chk("rst_rdata", apu_rdata, 0);
    chk("rst_rflags", apu_rflags, 0);
    chk("rst_rid", apu_rid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf_err, 0);
    fpu_gnt = 1'b0;
    #1;
    chk("rst_gnt_follow", apu_gnt, 0);

    apu_rready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      apu_req = vecs[i].req; fpu_gnt = vecs[i].gnt; apu_id = vecs[i].id;
      apu_op = vecs[i].op; apu_flags = vecs[i].flags; apu_opnd = vecs[i].opnd;
      #1;
      chk("vec_fpu_req", fpu_req, vecs[i].exp_freq);
      chk("vec_apu_gnt", apu_gnt, vecs[i].exp_agnt);
      chk("vec_fpu_id", fpu_id, vecs[i].id);
      chk("vec_fpu_op", fpu_op, vecs[i].op);
      chk("vec_fpu_flags", fpu_flags, vecs[i].flags);
      chk("vec_fpu_opnd", fpu_opnd, vecs[i].opnd);
    end
    @(negedge clk);
    apu_req = 1'b0; fpu_gnt = 1'b1; apu_op = 6'h0b; apu_flags = 15'h0013;
    wait_idle();

    // Back-to-back: sustained issue, in-order return, busy falls after last pop.
    pc0 = pop_cnt;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      apu_req = 1'b1; apu_id = 9'(i); apu_opnd = mk_opnd(9'(i));
      #1;
      chk("b2b_gnt", apu_gnt, 1);
    end
    @(negedge clk);
    apu_req = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      #1;
      if (apu_rvalid && pop_cnt == pc0 + 7) begin
        found = 1'b1;
        chk("b2b_busy_last", busy, 1);
        @(negedge clk);
        #1;
        chk("b2b_busy_drop", busy, 0);
      end else begin
        @(negedge clk);
      end
    end
    chk("b2b_last_pop_seen", found, 1);
    wait_idle();

    // Back-pressure: four credits, then stall until the consumer drains.
    apu_rready = 1'b0;
    granted = 0;
    tag = 9'h010;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      apu_req = 1'b1; apu_id = tag; apu_opnd = mk_opnd(tag);
      #1;
      if (apu_gnt) begin granted++; tag++; end
    end
    chk("bp_granted", granted, 4);
    chk("bp_gnt_low", apu_gnt, 0);
    chk("bp_rvalid", apu_rvalid, 1);
    apu_rready = 1'b1;
    for (int k = 0; k < 40 && granted < 6; k++) begin
      @(negedge clk);
      apu_req = 1'b1; apu_id = tag; apu_opnd = mk_opnd(tag);
      #1;
      if (apu_gnt) begin granted++; tag++; end
    end
    @(negedge clk);
    apu_req = 1'b0;
    chk("bp_all_granted", granted, 6);
    wait_idle();
    chk("bp_no_ovf", ovf_err, 0);

    // Stable hold with rready toggling.
    apu_rready = 1'b0;
    issue_one(9'h0de, {32'h0, 32'h0, 32'hDEADBEEF});
    issue_one(9'h0df, mk_opnd(9'h0df));
    repeat (4) @(negedge clk);
    #1;
    chk("hold_head_data", apu_rdata, 32'hDEADBEEF);
    chk("hold_head_id", apu_rid, 9'h0de);
    pc0 = pop_cnt;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      apu_rready = k[0];
    end
    @(negedge clk);
    apu_rready = 1'b0;
    chk("hold_pop_count", pop_cnt - pc0, 2);
    chk("hold_empty", apu_rvalid, 0);

    // Simultaneous push/pop at count=3.
    issue_one(9'h030, mk_opnd(9'h030));
    issue_one(9'h031, mk_opnd(9'h031));
    issue_one(9'h032, mk_opnd(9'h032));
    repeat (4) @(negedge clk);
    #1;
    chk("sim_gnt_count3", apu_gnt, 1);
    issue_one(9'h033, mk_opnd(9'h033));
    #1;
    chk("sim_gnt_blocked", apu_gnt, 0);
    c = 0;
    while (!fpu_rvalid && c < 5) begin
      @(negedge clk);
      #1;
      c++;
    end
    chk("sim_rvalid_seen", fpu_rvalid, 1);
    apu_rready = 1'b1;
    @(negedge clk);
    apu_rready = 1'b0;
    #1;
    chk("sim_gnt_after", apu_gnt, 1);
    issue_one(9'h034, mk_opnd(9'h034));
    #1;
    chk("sim_count_is3", apu_gnt, 0);
    apu_rready = 1'b1;
    wait_idle();

    // Error injection with one response buffered.
    apu_rready = 1'b0;
    issue_one(9'h0e0, mk_opnd(9'h0e0));
    repeat (4) @(negedge clk);
    #1;
    chk("err_pre_ovf", ovf_err, 0);
    inj = 1'b1;
    @(negedge clk);
    man_v = 1'b1; man_d = 32'h0BADF00D;
    @(negedge clk);
    man_v = 1'b0;
    #1;
    chk("err_ovf_set", ovf_err, 1);
    chk("err_rvalid_kept", apu_rvalid, 1);
    chk("err_head_id", apu_rid, 9'h0e0);
    repeat (3) @(negedge clk);
    inj = 1'b0;
    #1;
    chk("err_ovf_sticky", ovf_err, 1);
    apu_rready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("err_single_entry", apu_rvalid, 0);
    chk("err_ovf_after_pop", ovf_err, 1);

    // Reset mid-operation with count=2, outstanding=2.
    apu_rready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      apu_req = 1'b1; apu_id = 9'(9'h040 + i); apu_opnd = mk_opnd(9'(9'h040 + i));
      #1;
      chk("mid_gnt", apu_gnt, 1);
    end
    @(negedge clk);
    #1;
    chk("mid_full", apu_gnt, 0);
    chk("mid_rvalid", apu_rvalid, 1);
    apu_req = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    #1;
    chk("mid_rst_gnt", apu_gnt, 1);
    chk("mid_rst_rvalid", apu_rvalid, 0);
    chk("mid_rst_payload", {apu_rdata, apu_rflags, apu_rid}, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ovf", ovf_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    apu_rready = 1'b1;
    apu_req = 1'b1; apu_id = 9'h055; apu_opnd = mk_opnd(9'h055);
    #1;
    chk("post_rst_gnt", apu_gnt, 1);
    @(negedge clk);
    apu_req = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apu_fpu_rsp_buffer.md
# apu_fpu_rsp_buffer

Parametrised successor of the cluster's FPU APU wrapper: sits between the shared-FPU interconnect (APU master side) and one FPU datapath (FPU side). It adds honest response back-pressure: `apu_rready_i` is honoured through a response FIFO of `RSP_DEPTH` entries. A credit counter throttles issue so the FPU output is never stalled, which keeps its `out_ready` permanently tied high. The ID tag is carried end to end, and drain/error status is exported for the cluster controller.

## Interface
- `ID_WIDTH`, 9: request/response tag width.
- `NB_ARGS`, 3: operands per request.
- `OPCODE_WIDTH`, 6: `apu_op_i` width.
- `DATA_WIDTH`, 32: operand/result width.
- `FLAGS_IN_WIDTH`, 15: request flags width.
- `FLAGS_OUT_WIDTH`, 5: response status width.
- `RSP_DEPTH`, 4: response FIFO entries and the maximum in-flight plus buffered operations (≥1).
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; one clock, asynchronous active-low reset.
- `apu_req_i`  in  1  request valid.
- `apu_gnt_o`  out  1  request accepted this cycle.
- `apu_ID_i`  in  ID_WIDTH  request tag.
- `apu_operands_i`  in  NB_ARGS*DATA_WIDTH  operands.
- `apu_op_i`  in  OPCODE_WIDTH  opcode.
- `apu_flags_i`  in  FLAGS_IN_WIDTH  flags.
- `apu_rready_i`  in  1  response consumer ready.
- `apu_rvalid_o`  out  1  response valid (FIFO non-empty).
- `apu_rdata_o`  out  DATA_WIDTH  result.
- `apu_rflags_o`  out  FLAGS_OUT_WIDTH  status.
- `apu_rID_o`  out  ID_WIDTH  response tag.
- `fpu_req_o`  out  1  issue valid to FPU.
- `fpu_gnt_i`  in  1  FPU input ready.
- `fpu_ID_o`, `fpu_operands_o`, `fpu_op_o`, `fpu_flags_o`  out  same widths as APU side  pass-through of request fields.
- `fpu_rvalid_i`  in  1  FPU result valid (never stalled).
- `fpu_rdata_i`, `fpu_rflags_i`, `fpu_rID_i`  in  as APU side  FPU result fields.
- `busy_o`  out  1  outstanding≠0 or FIFO non-empty.
- `ovf_err_o`  out  1  sticky: push attempted into a full FIFO.

## Operation
- State is `outstanding` (0..RSP_DEPTH), FIFO `count` (0..RSP_DEPTH), and head/tail pointers. All counters use width $clog2(RSP_DEPTH+1).
- `credit_ok = (outstanding + count) < RSP_DEPTH`, computed from registered values. A pop in the current cycle does not free a credit until the next cycle.
- `fpu_req_o = apu_req_i & credit_ok`. `apu_gnt_o = fpu_gnt_i & credit_ok`. Request fields pass through combinationally.
- Issue event is `fpu_req_o & fpu_gnt_i`, which increments `outstanding`. `fpu_rvalid_i` decrements it. On a simultaneous issue and result, `outstanding` is unchanged.
- `fpu_rvalid_i` pushes {rdata, rflags, rID} into the FIFO. Pop occurs on `apu_rvalid_o & apu_rready_i`. Push and pop in the same cycle leave `count` unchanged, including when count = RSP_DEPTH−1 or count = 1.
- FIFO is show-ahead. APU outputs come from the head entry. The payload is held stable while `apu_rvalid_o & !apu_rready_i`.
- Order: responses leave in FPU completion order. No reordering by ID.
- `fpu_rvalid_i` with `outstanding == 0`, or a push when full without a pop, sets `ovf_err_o`. The payload is dropped and the counters saturate (no wrap). A pop when empty is impossible by construction.
- Pointers wrap modulo RSP_DEPTH. Non-power-of-two depth is supported.
- Reset (including mid-operation) clears counters, pointers and the error flag. FPU results already in flight are expected to be flushed by the FPU's own reset.

## Timing
- Reset values: `apu_gnt_o`=`fpu_gnt_i` (credit_ok=1 after reset), `apu_rvalid_o`=0, `apu_rdata_o`/`apu_rflags_o`/`apu_rID_o`=0, `busy_o`=0, `ovf_err_o`=0.
- Added latency: a response pushed in cycle N appears on `apu_rvalid_o` in cycle N+1. There is no bypass path.
- Throughput: 1 op/cycle sustained when `apu_rready_i`=1 and FPU latency L satisfies L+1 < RSP_DEPTH. Otherwise issue is credit-limited to RSP_DEPTH ops per (L+2) cycles.
- The only combinational APU↔FPU paths are request fields and the gnt/req handshake. The response path is fully registered.

## Test plan
- Back-to-back: RSP_DEPTH=4, FPU latency 2, rready=1, 8 requests with tags 0..7 → 8 responses with tags 0..7 in order; each appears 1 cycle after its `fpu_rvalid_i`; `busy_o` drops the cycle after the last pop.
- Back-pressure: rready=0, 6 requests → exactly 4 granted; `apu_gnt_o`=0 while outstanding+count=4; raise rready → 4 responses, then the remaining 2 are granted and returned; no `ovf_err_o`.
- Stable hold: rready toggles 0/1 every cycle with a response 0xDEADBEEF at the head → data, flags and ID stable while stalled; each pops exactly once.
- Simultaneous push/pop at count=3, DEPTH=4 → count stays 3; `apu_gnt_o` follows `fpu_gnt_i` only when outstanding=0.
- Error injection: `fpu_rvalid_i` pulsed with outstanding=0 → `ovf_err_o`=1 and stays 1; FIFO count unchanged.
- Reset mid-operation: assert rst_n=0 with count=2 and outstanding=2 → next cycle all outputs at reset values; post-reset request granted immediately.
